lsu_ctrl: RTL

- Load/store unit directly downstream of the control-signal decoder. It consumes the decoder's mem_rd_en, mem_wr_en and mem_op, plus the ALU address and rs2 data.
- Runs a single outstanding request on the data-memory valid/ready bus.
- Returns aligned, sign- or zero-extended load data, or a fault, to writeback.
- Keeps the core's memory stage blocked via in_ready while busy.

---
 rtl/lsu_ctrl_if.sv | 55 +++++
 rtl/lsu_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl_if
//  Description : Data-memory valid/ready bus between the load/store unit and
//                the data memory. One request channel (valid/ready) and one
//                response channel (valid only, always accepted).
//  Modports    : master - the LSU side (drives requests, consumes responses)
//                slave  - the memory side (accepts requests, drives responses)
//  Signals     : mem_req_valid  request valid
//                mem_req_ready  memory accepts the request
//                mem_req_we     1 = write
//                mem_req_addr   word-aligned byte address
//                mem_req_wdata  lane-replicated store data
//                mem_req_wstrb  byte enables (0000 on reads)
//                mem_resp_valid response valid
//                mem_resp_rdata read word
//                mem_resp_err   bus error
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_ctrl_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;

    modport master (
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req_we,
        output mem_req_addr,
        output mem_req_wdata,
        output mem_req_wstrb,
        input  mem_resp_valid,
        input  mem_resp_rdata,
        input  mem_resp_err
    );

    modport slave (
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req_we,
        input  mem_req_addr,
        input  mem_req_wdata,
        input  mem_req_wstrb,
        output mem_resp_valid,
        output mem_resp_rdata,
        output mem_resp_err
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Load/store unit sitting after the control decoder. Accepts
//                one memory-stage request at a time, issues a single
//                outstanding access on the data-memory bus, and returns
//                aligned and extended load data or a fault to writeback.
//                The memory stage is held off through in_ready while busy.
//  Parameters  : TIMEOUT_CYCLES - cycles to wait for a response before an
//                                 access fault (0 disables the timeout)
//                CNT_W          - timeout counter width
//  Ports       : clk, rst_n     clock / asynchronous active-low reset
//                in_valid/in_ready            memory-stage handshake
//                mem_rd_en, mem_wr_en, mem_op decoder controls
//                addr, wdata                  effective address, rs2 data
//                mem (lsu_ctrl_if.master)     data-memory bus
//                out_valid, out_rdata, out_err, out_cause  completion
//  Config      : `define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
//                accesses in IDLE (cause 4 load / 6 store, no bus access).
//                Without it, sub-word address bits are simply ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        in_valid,
    output logic             in_ready,
    input  wire logic        mem_rd_en,
    input  wire logic        mem_wr_en,
    input  wire logic [2:0]  mem_op,
    input  wire logic [31:0] addr,
    input  wire logic [31:0] wdata,
    lsu_ctrl_if.master       mem,
    output logic             out_valid,
    output logic [31:0]      out_rdata,
    output logic             out_err,
    output logic [3:0]       out_cause
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] c_CAUSE_ILLEGAL  = 4'd2;
    localparam logic [3:0] c_CAUSE_LD_ACC   = 4'd5;
    localparam logic [3:0] c_CAUSE_ST_ACC   = 4'd7;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic [3:0] c_CAUSE_LD_MIS   = 4'd4;
    localparam logic [3:0] c_CAUSE_ST_MIS   = 4'd6;
`endif

    localparam bit             c_TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] c_TMO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              is_load_q,   is_load_d;
    logic [2:0]        op_q,        op_d;
    logic [1:0]        addr_lo_q,   addr_lo_d;
    logic              req_we_q,    req_we_d;
    logic [31:0]       req_addr_q,  req_addr_d;
    logic [31:0]       req_wdata_q, req_wdata_d;
    logic [3:0]        req_wstrb_q, req_wstrb_d;
    logic [31:0]       rdata_q,     rdata_d;
    logic              err_q,       err_d;
    logic [3:0]        cause_q,     cause_d;

    // ------------------------------------------------------------------
    // Request decode (combinational on the incoming request)
    // ------------------------------------------------------------------
    logic        w_ld_legal;
    logic        w_st_legal;
    logic        w_illegal;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;

    always_comb begin
        w_ld_legal = (mem_op == 3'b000) || (mem_op == 3'b001) || (mem_op == 3'b010) ||
                     (mem_op == 3'b100) || (mem_op == 3'b101);
        w_st_legal = (mem_op == 3'b000) || (mem_op == 3'b001) || (mem_op == 3'b010);
        w_illegal  = (mem_rd_en && mem_wr_en) ||
                     (mem_rd_en && !w_ld_legal) ||
                     (mem_wr_en && !w_st_legal);
    end

    // Store lane steering: data is replicated so the memory can pick the
    // enabled lanes without knowing the access size.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0;
        if (mem_wr_en) begin
            case (mem_op[1:0])
                2'b00: begin
                    w_wstrb = 4'b0001 << addr[1:0];
                    w_wdata = {4{wdata[7:0]}};
                end
                2'b01: begin
                    w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = wdata;
                end
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    always_comb begin
        w_misalign = ((mem_op[1:0] == 2'b01) && addr[0]) ||
                     ((mem_op[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end
`endif

    // Load extraction: byte lanes select by addr[1:0], halves by addr[1];
    // words take the full bus word.
    function automatic logic [31:0] load_extract(
        input logic [2:0]  op,
        input logic [1:0]  lo,
        input logic [31:0] word
    );
        logic [31:0] sh_b;
        logic [31:0] sh_h;
        logic [31:0] res;
        sh_b = word >> {lo, 3'b000};
        sh_h = word >> {lo[1], 4'b0000};
        case (op)
            3'b000:  res = {{24{sh_b[7]}}, sh_b[7:0]};
            3'b100:  res = {24'h0, sh_b[7:0]};
            3'b001:  res = {{16{sh_h[15]}}, sh_h[15:0]};
            3'b101:  res = {16'h0, sh_h[15:0]};
            3'b010:  res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_load_d   = is_load_q;
        op_d        = op_q;
        addr_lo_d   = addr_lo_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cause_d     = cause_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    is_load_d = mem_rd_en;
                    op_d      = mem_op;
                    addr_lo_d = addr[1:0];
                    rdata_d   = 32'h0;
                    err_d     = 1'b0;
                    cause_d   = 4'd0;
                    if (w_illegal) begin
                        err_d   = 1'b1;
                        cause_d = c_CAUSE_ILLEGAL;
                        state_d = S_DONE;
                    end else if (!mem_rd_en && !mem_wr_en) begin
                        // Not a memory instruction: complete without a bus access.
                        state_d = S_DONE;
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    else if (w_misalign) begin
                        err_d   = 1'b1;
                        cause_d = mem_rd_en ? c_CAUSE_LD_MIS : c_CAUSE_ST_MIS;
                        state_d = S_DONE;
                    end
`endif
                    else begin
                        req_we_d    = mem_wr_en;
                        req_addr_d  = {addr[31:2], 2'b00};
                        req_wdata_d = w_wdata;
                        req_wstrb_d = w_wstrb;
                        state_d     = S_REQ;
                    end
                end
            end

            S_REQ: begin
                if (mem.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // A response in the expiry cycle takes priority over the timeout.
                if (mem.mem_resp_valid) begin
                    err_d   = mem.mem_resp_err;
                    cause_d = mem.mem_resp_err ?
                              (is_load_q ? c_CAUSE_LD_ACC : c_CAUSE_ST_ACC) : 4'd0;
                    rdata_d = (is_load_q && !mem.mem_resp_err) ?
                              load_extract(op_q, addr_lo_q, mem.mem_resp_rdata) : 32'h0;
                    state_d = S_DONE;
                end else if (c_TMO_EN && (cnt_q == c_TMO_LAST)) begin
                    err_d   = 1'b1;
                    cause_d = is_load_q ? c_CAUSE_LD_ACC : c_CAUSE_ST_ACC;
                    rdata_d = 32'h0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_load_q   <= 1'b0;
            op_q        <= 3'b000;
            addr_lo_q   <= 2'b00;
            req_we_q    <= 1'b0;
            req_addr_q  <= 32'h0;
            req_wdata_q <= 32'h0;
            req_wstrb_q <= 4'b0000;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            cause_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_load_q   <= is_load_d;
            op_q        <= op_d;
            addr_lo_q   <= addr_lo_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cause_q     <= cause_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state so reset removes them immediately.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready          = (state_q == S_IDLE);
        out_valid         = (state_q == S_DONE);
        out_rdata         = out_valid ? rdata_q : 32'h0;
        out_err           = out_valid & err_q;
        out_cause         = out_valid ? cause_q : 4'd0;
        mem.mem_req_valid = (state_q == S_REQ);
        mem.mem_req_we    = req_we_q;
        mem.mem_req_addr  = req_addr_q;
        mem.mem_req_wdata = req_wdata_q;
        mem.mem_req_wstrb = req_wstrb_q;
    end

endmodule
`default_nettype wire
